// File: rtl/alu_pkg.sv
// Shared opcode encodings for the registered ALU, used by the datapath,
// the sequencer and the bench.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result for the selected opcode and the
// carry of A+B, which is produced regardless of the opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] quot_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign carry  = sum_s[WIDTH];
    // Division by zero saturates to all ones rather than leaving it undefined.
    assign quot_s = (b == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : (a / b);

    // Opcode decode for the next result.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (alu_sel)
            OP_ADD:  result = sum_s[WIDTH-1:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = quot_s;
            OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered unsigned ALU: one-cycle latency from operands/opcode to
// ALU_Out and CarryOut, cleared asynchronously by rst_n.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut
);

    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic [WIDTH-1:0] alu_out_r;
    logic             carry_out_r;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (A),
        .b       (B),
        .alu_sel (ALU_Sel),
        .result  (result_s),
        .carry   (carry_s)
    );

    // Output register capturing the datapath result each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_r   <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
        end else begin
            alu_out_r   <= result_s;
            carry_out_r <= carry_s;
        end
    end

    assign ALU_Out  = alu_out_r;
    assign CarryOut = carry_out_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences
// and randomized vectors against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALU_Sel;
    logic [W-1:0] ALU_Out;
    logic         CarryOut;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_out;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed with plain integer arithmetic.
    function automatic int ref_out(input int a, input int b, input int sel);
        case (sel)
            0:  return (a + b) % MOD;
            1:  return (a - b + MOD) % MOD;
            2:  return (a * b) % MOD;
            3:  return (b == 0) ? MOD - 1 : a / b;
            4:  return (a * 2) % MOD;
            5:  return a / 2;
            6:  return (a * 2) % MOD + a / (MOD / 2);
            7:  return a / 2 + (a % 2) * (MOD / 2);
            8:  return a & b;
            9:  return a | b;
            10: return a ^ b;
            11: return (MOD - 1) - (a | b);
            12: return (MOD - 1) - (a & b);
            13: return (MOD - 1) - (a ^ b);
            14: return (a > b) ? 1 : 0;
            15: return (a == b) ? 1 : 0;
            default: return -1;
        endcase
    endfunction

    function automatic int ref_carry(input int a, input int b);
        return ((a + b) >= MOD) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                           input logic [7:0] eo, input logic ec);
        vec_t v;
        v.a = a; v.b = b; v.sel = sel; v.exp_out = eo; v.exp_carry = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        A = a; B = b; ALU_Sel = sel;
    endtask

    initial begin
        logic [7:0] sweep_exp [16];
        logic [7:0] ra, rb;
        logic [3:0] rs;
        logic [7:0] held;

        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
        for (int i = 0; i < 16; i++) add_vec(8'h0A, 8'h02, i[3:0], sweep_exp[i], 1'b0);
        add_vec(8'hF6, 8'h0A, OP_ADD, 8'h00, 1'b1);
        add_vec(8'hF6, 8'h0A, OP_SUB, 8'hEC, 1'b1);
        add_vec(8'hF6, 8'h0A, OP_MUL, 8'h9C, 1'b1);
        add_vec(8'hF6, 8'h0A, OP_GT,  8'h01, 1'b1);
        add_vec(8'h02, 8'h0A, OP_SUB, 8'hF8, 1'b0);
        add_vec(8'h37, 8'h00, OP_DIV, 8'hFF, 1'b0);
        add_vec(8'h81, 8'h00, OP_ROL, 8'h03, 1'b0);
        add_vec(8'h81, 8'h00, OP_ROR, 8'hC0, 1'b0);
        add_vec(8'h80, 8'h00, OP_SHL, 8'h00, 1'b0);
        add_vec(8'h5A, 8'h5A, OP_EQ,   8'h01, 1'b0);
        add_vec(8'h5A, 8'h5A, OP_GT,   8'h00, 1'b0);
        add_vec(8'h5A, 8'h5A, OP_XNOR, 8'hFF, 1'b0);

        // Reset held from time zero with nonzero inputs
        rst_n = 1'b0;
        drive(8'h0A, 8'h02, OP_ADD);
        #2;
        check("reset_out", int'(ALU_Out), 0);
        check("reset_carry", int'(CarryOut), 0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_hold_out", int'(ALU_Out), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_load", int'(ALU_Out), 8'h0C);

        // Asynchronous reset mid-cycle after a carrying result
        drive(8'hF6, 8'h0A, OP_ADD);
        @(posedge clk); #1;
        check("pre_rst_carry", int'(CarryOut), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", int'(ALU_Out), 0);
        check("async_rst_carry", int'(CarryOut), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out", int'(ALU_Out), 8'h00);
        check("post_rst_carry", int'(CarryOut), 1);

        // Directed vector table, one vector per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", i), int'(ALU_Out), int'(vecs[i].exp_out));
            check($sformatf("vec%0d_carry", i), int'(CarryOut), int'(vecs[i].exp_carry));
        end

        // Overflow operands: carry set for every opcode
        for (int s = 0; s < 16; s++) begin
            drive(8'hF6, 8'h0A, s[3:0]);
            @(posedge clk); #1;
            check($sformatf("ovf_sel%0d_out", s), int'(ALU_Out), ref_out(246, 10, s));
            check($sformatf("ovf_sel%0d_carry", s), int'(CarryOut), 1);
        end

        // Input changes between edges must not reach the outputs
        drive(8'h33, 8'h11, OP_XOR);
        @(posedge clk); #1;
        held = ALU_Out;
        check("hold_base", int'(held), 8'h22);
        drive(8'hFF, 8'hFF, OP_ADD);
        #3;
        check("hold_out", int'(ALU_Out), 8'h22);
        check("hold_carry", int'(CarryOut), 0);
        @(posedge clk); #1;
        check("hold_next_out", int'(ALU_Out), 8'hFE);
        check("hold_next_carry", int'(CarryOut), 1);

        // Randomized vectors against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            drive(ra, rb, rs);
            @(posedge clk); #1;
            check($sformatf("rand%0d_out", n), int'(ALU_Out), ref_out(int'(ra), int'(rb), int'(rs)));
            check($sformatf("rand%0d_carry", n), int'(CarryOut), ref_carry(int'(ra), int'(rb)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
